// File: rtl/port_io_pkg.sv
// Shared definitions for the memory-mapped port blocks: UART transmitter
// state encodings and the bit layout of the status byte.
package port_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_MSB = 6;

  // Bit 7 of the status byte always reads as zero.
  function automatic logic [7:0] make_status(input logic full, input logic empty,
                                             input logic busy, input logic ovf,
                                             input logic [2:0] count);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_FULL_BIT]  = full;
    s[STATUS_EMPTY_BIT] = empty;
    s[STATUS_BUSY_BIT]  = busy;
    s[STATUS_OVF_BIT]   = ovf;
    s[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
    return s;
  endfunction

endpackage

// File: rtl/port_uart_tx_if.sv
// CPU-side port bundle of the UART transmitter: write port, overflow clear,
// status read port and the serial line.
interface port_uart_tx_if;
  logic [7:0] port_data;
  logic       port_write;
  logic       clr_ovf;
  logic       tx;
  logic [7:0] status;

  modport master (output port_data, port_write, clr_ovf, input tx, status);
  modport slave  (input port_data, port_write, clr_ovf, output tx, status);
endinterface

// File: rtl/port_uart_tx_byte_fifo.sv
// Byte FIFO with power-of-two depth. The caller must only push when not
// full (or while popping) and only pop when not empty.
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/port_uart_tx.sv
// 8N1 UART transmitter fed from a CPU output port through a byte FIFO,
// with a sticky overflow flag and a status byte for a CPU input port.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  port_uart_tx_if.slave  bus
);
  import port_io_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state, state_next;
  logic [7:0]    baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shreg, shreg_next;
  logic          overflow;
  logic          baud_done;
  logic          tx_line;
  logic [2:0]    count_lo;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.port_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A write into a full FIFO is still accepted when the FSM frees a slot on the same edge.
  assign fifo_push = bus.port_write && (!fifo_full || fifo_pop);
  assign baud_done = (baud_cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= 8'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_next = fifo_dout;
          baud_next  = 8'd0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = 8'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 8'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = 8'd0;
          shreg_next = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_next   = 3'd0;
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + 8'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = 8'd0;
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shreg_next = fifo_dout;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line is decoded from registered state only, so reset forces it high immediately.
  always_comb begin
    tx_line = 1'b1;
    case (state)
      START:   tx_line = 1'b0;
      DATA:    tx_line = shreg[0];
      default: tx_line = 1'b1;
    endcase
  end

  // A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (bus.port_write && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign count_lo   = 3'(fifo_count);
  assign bus.tx     = tx_line;
  assign bus.status = make_status(fifo_full, fifo_empty, state != IDLE, overflow, count_lo);

endmodule

// File: tb/tb_port_uart_tx.sv
// Scoreboard bench for port_uart_tx: stimulus queues expected bytes, a line
// monitor decodes every frame cycle by cycle and compares against the queue.
module tb_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cycle_cnt = 0;
  logic in_frame = 1'b0;
  logic [7:0] exp_q[$];
  int   frame_starts[$];

  port_uart_tx_if bus();

  port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one write strobe for one cycle; queues the byte when it should be accepted.
  task automatic apply_stimulus(input logic [7:0] data, input logic accept);
    bus.port_data  = data;
    bus.port_write = 1'b1;
    if (accept) exp_q.push_back(data);
    @(negedge clk);
    bus.port_write = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_gaps(input string name, input int base, input int frames);
    check_output({name, "_frames"}, frame_starts.size() - base, frames);
    for (int i = base + 1; i < frame_starts.size(); i++)
      check_output({name, "_gap"}, frame_starts[i] - frame_starts[i-1], 10 * CPB);
  endtask

  // Line monitor: checks every cycle of each frame against the scoreboard head.
  initial begin : monitor
    logic       prev_tx;
    logic [9:0] frame_bits;
    logic [7:0] expected;
    logic [7:0] rx;
    logic       have_exp;
    logic       aborted;
    int         shape_err;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_tx = 1'b1;
        continue;
      end
      if (prev_tx && !bus.tx) begin
        in_frame = 1'b1;
        frame_starts.push_back(cycle_cnt);
        have_exp = (exp_q.size() != 0);
        expected = have_exp ? exp_q.pop_front() : 8'h00;
        frame_bits = {1'b1, expected, 1'b0};
        rx = 8'h00;
        aborted = 1'b0;
        shape_err = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          if (bus.tx !== frame_bits[k / CPB]) shape_err++;
          if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8)
            rx[(k / CPB) - 1] = bus.tx;
        end
        in_frame = 1'b0;
        if (!aborted) begin
          if (!have_exp) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got byte %0h, expected no frame", rx);
          end else begin
            check_output("frame_byte", rx, expected);
            check_output("frame_shape_errs", shape_err, 0);
          end
        end
        prev_tx = 1'b1;
      end else begin
        prev_tx = bus.tx;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int base;
    reset          = 1'b0;
    bus.port_data  = 8'h00;
    bus.port_write = 1'b0;
    bus.clr_ovf    = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_status", bus.status, 8'h02);
    check_output("reset_tx", bus.tx, 1'b1);
    reset = 1'b1;

    $display("[TB] idle hold after reset");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_output("idle_tx", bus.tx, 1'b1);
      check_output("idle_status", bus.status, 8'h02);
    end

    $display("[TB] single byte 0xA5");
    base = frame_starts.size();
    apply_stimulus(8'hA5, 1'b1);
    check_output("single_captured_tx", bus.tx, 1'b1);
    check_output("single_captured_status", bus.status, 8'h10);
    @(negedge clk);
    check_output("single_start_tx", bus.tx, 1'b0);
    check_output("single_start_status", bus.status, 8'h06);
    wait_drain("single");
    check_gaps("single", base, 1);
    check_output("single_end_status", bus.status, 8'h02);

    $display("[TB] five back-to-back writes");
    base = frame_starts.size();
    for (int i = 1; i <= 5; i++) apply_stimulus(8'(i), 1'b1);
    check_output("five_full_status", bus.status, 8'h45);
    wait_drain("five");
    check_gaps("five", base, 5);
    check_output("five_end_status", bus.status, 8'h02);

    $display("[TB] six writes with overflow");
    base = frame_starts.size();
    for (int i = 1; i <= 6; i++) apply_stimulus(8'(i), i <= 5);
    check_output("six_ovf_status", bus.status, 8'h4D);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check_output("six_clr_status", bus.status, 8'h45);
    wait_drain("six");
    check_gaps("six", base, 5);
    check_output("six_end_status", bus.status, 8'h02);

    $display("[TB] write coinciding with pop from full FIFO");
    base = frame_starts.size();
    for (int i = 0; i < 5; i++) apply_stimulus(8'h11 + 8'(i), 1'b1);
    repeat (36) @(negedge clk);
    check_output("coinc_before_status", bus.status, 8'h45);
    apply_stimulus(8'h16, 1'b1);
    check_output("coinc_after_status", bus.status, 8'h45);
    wait_drain("coinc");
    check_gaps("coinc", base, 6);
    check_output("coinc_end_status", bus.status, 8'h02);

    $display("[TB] reset during data bit 3");
    apply_stimulus(8'hA5, 1'b1);
    apply_stimulus(8'h3C, 1'b1);
    check_output("abort_start_tx", bus.tx, 1'b0);
    repeat (16) @(posedge clk);
    #2;
    check_output("abort_bit3_tx", bus.tx, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_output("abort_async_tx", bus.tx, 1'b1);
    check_output("abort_async_status", bus.status, 8'h02);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    base = frame_starts.size();
    @(negedge clk);
    check_output("abort_release_status", bus.status, 8'h02);
    repeat (100) @(negedge clk);
    check_output("abort_no_residual", frame_starts.size() - base, 0);
    check_output("abort_final_tx", bus.tx, 1'b1);
    check_output("abort_final_status", bus.status, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
